// File: rtl/i2c_master_if.sv
`timescale 1ns/1ps
// i2c_master_if: host handshake and open-drain SCL/SDA pair of the I2C master.
// The master modport is the controller's view of the bundle.
// The slave modport is the view of the host and bus model that sit on the far side.
interface i2c_master_if;
    logic       enable;
    logic       start;
    logic [6:0] address;
    logic       read_write_flag;
    logic [7:0] byte_count;
    logic [7:0] data_write;
    logic       data_load;
    logic [7:0] data_read;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       error;
    logic       scl_in;
    logic       scl_out;
    logic       sda_in;
    logic       sda_out;

    modport master (
        input  enable, start, address, read_write_flag, byte_count, data_write,
        input  scl_in, sda_in,
        output data_load, data_read, data_valid, busy, done, error,
        output scl_out, sda_out
    );

    modport slave (
        output enable, start, address, read_write_flag, byte_count, data_write,
        output scl_in, sda_in,
        input  data_load, data_read, data_valid, busy, done, error,
        input  scl_out, sda_out
    );
endinterface

// File: rtl/i2c_master.sv
`timescale 1ns/1ps
// i2c_master: single-master I2C controller (START, addr/RW byte, data bytes, STOP) on open-drain SCL/SDA.
// Latency: busy and SDA low one clock after an accepted start; one bit per CLK_DIV clocks, 9 bits per byte.
// Backpressure: start ignored while busy or during done; I2C_MASTER_CLOCK_STRETCH_EN lets a slave hold SCL low.
module i2c_master #(
    parameter int CLK_DIV = 8
) (
    input  logic         clock,
    input  logic         reset,
    i2c_master_if.master ifc
);
    // Phase counter holds clocks elapsed since the SCL falling edge of the current bit.
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] C_QTR  = CW'(CLK_DIV / 4);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] C_SMP  = CW'(CLK_DIV / 2 + CLK_DIV / 4);
    localparam logic [CW-1:0] C_FULL = CW'(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP,
        BUS_FREE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic [7:0]    rem_q;
    logic          rw_q;
    logic          nack_q;
    logic          scl_q;
    logic          sda_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          load_q;
    logic          valid_q;
    logic [7:0]    rd_q;

    logic          in_bit_d;
    logic          hold_d;
    logic [CW-1:0] cnt_inc_d;
    logic          drv_d;
    logic          high_d;
    logic          smp_d;
    logic          end_d;

    assign ifc.scl_out    = scl_q;
    assign ifc.sda_out    = sda_q;
    assign ifc.busy       = busy_q;
    assign ifc.done       = done_q;
    assign ifc.error      = error_q;
    assign ifc.data_load  = load_q;
    assign ifc.data_valid = valid_q;
    assign ifc.data_read  = rd_q;

`ifndef I2C_MASTER_CLOCK_STRETCH_EN
    // Without stretching the bus SCL level plays no part in timing.
    logic unused_scl_in;
    assign unused_scl_in = ifc.scl_in;
`endif

    // Bit-cell timing strobes: SDA drive, SCL rise, SDA sample and bit end.
    always_comb begin
        in_bit_d = (state_q == ADDR)  || (state_q == ADDR_ACK) ||
                   (state_q == WRITE) || (state_q == WRITE_ACK) ||
                   (state_q == READ)  || (state_q == READ_ACK);
        hold_d   = 1'b0;
`ifdef I2C_MASTER_CLOCK_STRETCH_EN
        // A slave holding SCL low while we release it freezes the high phase.
        hold_d   = scl_q && !ifc.scl_in && (in_bit_d || (state_q == STOP)) && (cnt_q >= C_HALF);
`endif
        cnt_inc_d = hold_d ? cnt_q : cnt_q + CW'(1);
        drv_d     = !hold_d && (cnt_inc_d == C_QTR);
        high_d    = !hold_d && (cnt_inc_d == C_HALF);
        smp_d     = !hold_d && (cnt_inc_d == C_SMP);
        end_d     = !hold_d && (cnt_inc_d == C_FULL);
    end

    // Transaction sequencer: line drive, shifting, byte accounting and host strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            rw_q    <= 1'b0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;

            // SCL waveform shared by every address, data and acknowledge bit.
            if (in_bit_d) begin
                cnt_q <= cnt_inc_d;
                if (high_d) scl_q <= 1'b1;
                if (end_d) begin
                    scl_q <= 1'b0;
                    cnt_q <= '0;
                end
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // The done cycle is excluded so a request cannot ride on the tail of the last one.
                    if (ifc.enable && ifc.start && !done_q) begin
                        sh_q    <= {ifc.address, ifc.read_write_flag};
                        rw_q    <= ifc.read_write_flag;
                        rem_q   <= ifc.byte_count;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        sda_q   <= 1'b0;
                        bit_q   <= '0;
                        state_q <= START;
                    end
                end

                START: begin
                    cnt_q <= cnt_inc_d;
                    if (cnt_inc_d == C_HALF) begin
                        scl_q   <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ADDR;
                    end
                end

                ADDR: begin
                    if (drv_d) sda_q <= sh_q[7];
                    if (end_d) begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (drv_d) sda_q <= 1'b1;
                    if (smp_d) nack_q <= ifc.sda_in;
                    if (end_d) begin
                        if (nack_q) begin
                            error_q <= 1'b1;
                            state_q <= STOP;
                        end else if (rem_q == 8'd0) begin
                            state_q <= STOP;
                        end else if (rw_q) begin
                            state_q <= READ;
                        end else begin
                            sh_q    <= ifc.data_write;
                            load_q  <= 1'b1;
                            state_q <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (drv_d) sda_q <= sh_q[7];
                    if (end_d) begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= WRITE_ACK;
                    end
                end

                WRITE_ACK: begin
                    if (drv_d) sda_q <= 1'b1;
                    if (smp_d) nack_q <= ifc.sda_in;
                    if (end_d) begin
                        if (nack_q) begin
                            error_q <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            rem_q <= rem_q - 8'd1;
                            if (rem_q == 8'd1) begin
                                state_q <= STOP;
                            end else begin
                                sh_q    <= ifc.data_write;
                                load_q  <= 1'b1;
                                state_q <= WRITE;
                            end
                        end
                    end
                end

                READ: begin
                    if (drv_d) sda_q <= 1'b1;
                    if (smp_d) begin
                        sh_q <= {sh_q[6:0], ifc.sda_in};
                        if (bit_q == 3'd7) begin
                            rd_q    <= {sh_q[6:0], ifc.sda_in};
                            valid_q <= 1'b1;
                        end
                    end
                    if (end_d) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rem_q   <= rem_q - 8'd1;
                            state_q <= READ_ACK;
                        end
                    end
                end

                READ_ACK: begin
                    // NACK the final byte so the slave lets go of SDA before STOP.
                    if (drv_d) sda_q <= (rem_q == 8'd0);
                    if (end_d) state_q <= (rem_q == 8'd0) ? STOP : READ;
                end

                STOP: begin
                    cnt_q <= cnt_inc_d;
                    if (drv_d)  sda_q <= 1'b0;
                    if (high_d) scl_q <= 1'b1;
                    if (end_d) begin
                        sda_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS_FREE;
                    end
                end

                BUS_FREE: begin
                    cnt_q <= cnt_inc_d;
                    if (cnt_inc_d == C_HALF) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
// tb_i2c_master: scoreboard bench with a clocked I2C slave model on the wired-AND bus.
module tb_i2c_master;
    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_if ifc ();

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clock (clk),
        .reset (rst),
        .ifc   (ifc.master)
    );

    // slave side of the open-drain bus
    logic s_scl = 1'b1;
    logic s_sda = 1'b1;
    assign ifc.scl_in = ifc.scl_out & s_scl;
    assign ifc.sda_in = ifc.sda_out & s_sda;

    // write data presented to the master, advanced on each data_load
    logic [7:0] wr_arr [0:7];
    int         wr_base = 0;
    int         n_load  = 0;
    int         n_done  = 0;
    int         n_stop  = 0;
    assign ifc.data_write = wr_arr[3'(n_load - wr_base)];

    // scoreboard queues
    logic [7:0] exp_bus  [$];
    logic [7:0] exp_rd   [$];
    logic       exp_mack [$];
    logic [7:0] s_txq    [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // host-side monitor
    always @(negedge clk) begin
        if (ifc.data_load === 1'b1) n_load++;
        if (ifc.done === 1'b1) n_done++;
        if (ifc.data_valid === 1'b1) begin
            if (exp_rd.size() == 0) check_eq("rd_queue", 32'(exp_rd.size()), 32'd1);
            else check_eq("data_read", {24'd0, ifc.data_read}, {24'd0, exp_rd.pop_front()});
        end
    end

    // slave model
    bit         s_addr_ack = 1'b1;
    bit         stretch_en = 1'b0;
    int         s_bit = 0;
    int         s_phase = 0;
    int         stretch_cnt = 0;
    logic [7:0] s_byte = '0;
    logic [7:0] s_cur;
    logic       s_rw = 1'b0;
    logic       s_nacked = 1'b0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       scl_b;
    logic       sda_b;

    always @(negedge clk) begin
        scl_b = ifc.scl_in;
        sda_b = ifc.sda_in;
        if (stretch_cnt > 0) begin
            stretch_cnt--;
            if (stretch_cnt == 0) s_scl = 1'b1;
        end
        if (p_scl && scl_b && p_sda && !sda_b) begin
            s_phase = 1; s_bit = 0; s_sda = 1'b1; s_nacked = 1'b0;
        end else if (p_scl && scl_b && !p_sda && sda_b) begin
            s_phase = 0; s_sda = 1'b1; n_stop++;
        end else if (s_phase != 0 && !p_scl && scl_b) begin
            if (s_bit < 8) s_byte = {s_byte[6:0], sda_b};
            else if (s_phase == 2 && s_rw) begin
                if (exp_mack.size() == 0) check_eq("mack_queue", 32'(exp_mack.size()), 32'd1);
                else check_eq("master_ack", {31'd0, sda_b}, {31'd0, exp_mack.pop_front()});
                if (sda_b) s_nacked = 1'b1;
            end
            s_bit++;
        end else if (s_phase != 0 && p_scl && !scl_b) begin
            if (s_bit == 8) begin
                if (s_phase == 1 || !s_rw) begin
                    if (exp_bus.size() == 0) check_eq("bus_queue", 32'(exp_bus.size()), 32'd1);
                    else check_eq("bus_byte", {24'd0, s_byte}, {24'd0, exp_bus.pop_front()});
                end
                if (s_phase == 1) begin
                    s_rw  = s_byte[0];
                    s_sda = s_addr_ack ? 1'b0 : 1'b1;
                end else if (!s_rw) begin
                    s_sda = 1'b0;
                end else begin
                    s_sda = 1'b1;
                    if (s_txq.size() > 0) void'(s_txq.pop_front());
                end
            end else if (s_bit == 9) begin
                if (s_phase == 1 && stretch_en) begin
                    s_scl = 1'b0;
                    stretch_cnt = 20;
                end
                s_bit = 0;
                s_phase = 2;
            end
            if (s_bit < 8) begin
                if (s_phase == 2 && s_rw && !s_nacked && s_txq.size() > 0) begin
                    s_cur = s_txq[0];
                    s_sda = s_cur[7 - s_bit];
                end else begin
                    s_sda = 1'b1;
                end
            end
        end
        p_scl = scl_b;
        p_sda = sda_b;
    end

    // one transaction: start latency, length, strobes and end state
    task automatic run_txn(input string name, input logic [6:0] a, input logic rw, input logic [7:0] cnt,
                           input logic exp_err, input int exp_loads, input int len_lo, input int len_hi,
                           input bit poke);
        int l0, d0, p0, cyc;
        bit seen;
        l0 = n_load; d0 = n_done; p0 = n_stop;
        wr_base = n_load;
        @(negedge clk);
        ifc.address = a; ifc.read_write_flag = rw; ifc.byte_count = cnt; ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        check_eq({name, "_busy_on"}, {31'd0, ifc.busy}, 32'd1);
        check_eq({name, "_sda_start"}, {31'd0, ifc.sda_out}, 32'd0);
        check_eq({name, "_err_clr"}, {31'd0, ifc.error}, 32'd0);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == HALF - 1) check_eq({name, "_scl_hi"}, {31'd0, ifc.scl_out}, 32'd1);
            if (cyc == HALF) check_eq({name, "_scl_lo"}, {31'd0, ifc.scl_out}, 32'd0);
            if (poke && cyc == 40) begin ifc.address = 7'h11; ifc.start = 1'b1; end
            if (poke && cyc == 41) ifc.start = 1'b0;
            if (ifc.done === 1'b1) begin
                seen = 1'b1;
                if (poke) ifc.start = 1'b1;
            end
        end
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({name, "_len_ok"}, {31'd0, (cyc >= len_lo && cyc <= len_hi)}, 32'd1);
        check_eq({name, "_busy_off"}, {31'd0, ifc.busy}, 32'd0);
        check_eq({name, "_error"}, {31'd0, ifc.error}, {31'd0, exp_err});
        check_eq({name, "_loads"}, 32'(n_load - l0), 32'(exp_loads));
        check_eq({name, "_dones"}, 32'(n_done - d0), 32'd1);
        check_eq({name, "_stops"}, 32'(n_stop - p0), 32'd1);
        check_eq({name, "_bus_left"}, 32'(exp_bus.size()), 32'd0);
        check_eq({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check_eq({name, "_mack_left"}, 32'(exp_mack.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        ifc.enable = 1'b1; ifc.start = 1'b0; ifc.address = '0;
        ifc.read_write_flag = 1'b0; ifc.byte_count = '0;
        for (int i = 0; i < 8; i++) wr_arr[i] = '0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_scl", {31'd0, ifc.scl_out}, 32'd1);
        check_eq("rst_sda", {31'd0, ifc.sda_out}, 32'd1);
        check_eq("rst_busy", {31'd0, ifc.busy}, 32'd0);
        check_eq("rst_done", {31'd0, ifc.done}, 32'd0);
        check_eq("rst_error", {31'd0, ifc.error}, 32'd0);
        check_eq("rst_load", {31'd0, ifc.data_load}, 32'd0);
        check_eq("rst_valid", {31'd0, ifc.data_valid}, 32'd0);
        check_eq("rst_rdata", {24'd0, ifc.data_read}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        // write two bytes
        wr_arr[0] = 8'h13; wr_arr[1] = 8'h57;
        exp_bus.push_back(8'hBA); exp_bus.push_back(8'h13); exp_bus.push_back(8'h57);
        run_txn("wr2", 7'h5D, 1'b0, 8'd2, 1'b0, 2, 228, 236, 1'b0);

        // read two bytes: master ACKs the first, NACKs the last
        s_txq.push_back(8'h9B); s_txq.push_back(8'hDF);
        exp_bus.push_back(8'hBB);
        exp_rd.push_back(8'h9B); exp_rd.push_back(8'hDF);
        exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
        run_txn("rd2", 7'h5D, 1'b1, 8'd2, 1'b0, 0, 228, 236, 1'b0);

        // wrong address: no ACK from the slave
        s_addr_ack = 1'b0;
        wr_arr[0] = 8'hEE;
        exp_bus.push_back(8'h44);
        run_txn("nack", 7'h22, 1'b0, 8'd1, 1'b1, 0, 84, 92, 1'b0);
        s_addr_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("err_held", {31'd0, ifc.error}, 32'd1);

        // address-only with starts while busy and on the done cycle
        exp_bus.push_back(8'h78);
        run_txn("cnt0", 7'h3C, 1'b0, 8'd0, 1'b0, 0, 84, 92, 1'b1);

        // reset in the middle of the first write byte
        wr_arr[0] = 8'hA5;
        exp_bus.push_back(8'hBA);
        wr_base = n_load;
        @(negedge clk);
        ifc.address = 7'h5D; ifc.read_write_flag = 1'b0; ifc.byte_count = 8'd1; ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        cyc = 0;
        while (ifc.data_load !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("rst_mid_load_seen", {31'd0, ifc.data_load}, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_scl", {31'd0, ifc.scl_out}, 32'd1);
        check_eq("rst_mid_sda", {31'd0, ifc.sda_out}, 32'd1);
        check_eq("rst_mid_busy", {31'd0, ifc.busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        check_eq("rst_mid_bus_left", 32'(exp_bus.size()), 32'd0);

        // normal write after the reset
        wr_arr[0] = 8'h3A;
        exp_bus.push_back(8'hBA); exp_bus.push_back(8'h3A);
        run_txn("post_rst", 7'h5D, 1'b0, 8'd1, 1'b0, 1, 156, 164, 1'b0);

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
        // slave stretches SCL after the address ACK; data must be intact, timing longer
        stretch_en = 1'b1;
        wr_arr[0] = 8'hC3;
        exp_bus.push_back(8'hBA); exp_bus.push_back(8'hC3);
        run_txn("stretch", 7'h5D, 1'b0, 8'd1, 1'b0, 1, 170, 186, 1'b0);
        stretch_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
